tag_cam_lookup: RTL

Pipelined, parametrised tag CAM: stores up to DEPTH tags with per-entry valid bits, accepts lookup requests through a valid/ready handshake and returns hit, highest matching index and a multi-hit flag two cycles later. Adds write, invalidate and flush ports, occupancy tracking and free-slot reporting. Sits between the prefetcher's address-tag bookkeeping and its request scheduler, replacing purely combinational tag matching on timing-critical paths.

---
 rtl/tag_cam_lookup_if.sv | 27 ++
 rtl/tag_cam_lookup.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tag_cam_lookup_if.sv
// tag_cam_lookup_if: lookup request / response handshake bundle for tag_cam_lookup.
//   slave  modport (CAM side):       lookupValid, lookupTag, respReady in;
//                                    lookupReady, respValid, respHit, respIdx, respMultiHit out
//   master modport (requester side): the reverse
interface tag_cam_lookup_if #(
  parameter int LOG_DEPTH = 3,
  parameter int TAG_SIZE  = 64
);
  logic                 lookupValid;
  logic                 lookupReady;
  logic [TAG_SIZE-1:0]  lookupTag;
  logic                 respValid;
  logic                 respReady;
  logic                 respHit;
  logic [LOG_DEPTH-1:0] respIdx;
  logic                 respMultiHit;

  modport master (
    output lookupValid, lookupTag, respReady,
    input  lookupReady, respValid, respHit, respIdx, respMultiHit
  );

  modport slave (
    input  lookupValid, lookupTag, respReady,
    output lookupReady, respValid, respHit, respIdx, respMultiHit
  );
endinterface

// File: rtl/tag_cam_lookup.sv
// tag_cam_lookup: pipelined tag CAM with per-entry valid bits.
//   Lookups enter stage A (request register), are compared in stage B against
//   the current array and land in the response register.
//   Optional feature macro: TAG_CAM_MULTIHIT_EN (adds the registered multi-hit flag;
//   when undefined respMultiHit is tied to 0).
// Ports:
//   clk, resetN         clock, asynchronous active-low reset
//   wrEn/wrIdx/wrTag    write a tag and set its valid bit
//   invEn/invIdx        clear one valid bit
//   flush               clear all valid bits (lowest maintenance priority)
//   lk                  lookup request / response handshake (slave modport)
//   freeIdx, full       lowest invalid entry, all-valid flag (from current valid vector)
//   count               registered number of valid entries
module tag_cam_lookup #(
  parameter int LOG_DEPTH = 3,
  parameter int TAG_SIZE  = 64
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 wrEn,
  input  logic [LOG_DEPTH-1:0] wrIdx,
  input  logic [TAG_SIZE-1:0]  wrTag,
  input  logic                 invEn,
  input  logic [LOG_DEPTH-1:0] invIdx,
  input  logic                 flush,
  tag_cam_lookup_if.slave      lk,
  output logic [LOG_DEPTH-1:0] freeIdx,
  output logic                 full,
  output logic [LOG_DEPTH:0]   count
);
  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [TAG_SIZE-1:0]  tags [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     valid_nxt;
  logic [LOG_DEPTH:0]   count_q;

  logic                 a_valid;
  logic [TAG_SIZE-1:0]  a_tag;
  logic                 r_valid;
  logic                 r_hit;
  logic [LOG_DEPTH-1:0] r_idx;

  logic [DEPTH-1:0]     match;
  logic                 hit_c;
  logic [LOG_DEPTH-1:0] idx_c;
  logic                 stall;

  function automatic logic [LOG_DEPTH:0] popcnt(input logic [DEPTH-1:0] v);
    logic [LOG_DEPTH:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {{LOG_DEPTH{1'b0}}, v[i]};
    return c;
  endfunction

  // Per-entry priority: write > invalidate > flush.
  always_comb begin
    valid_nxt = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wrEn && wrIdx == LOG_DEPTH'(i))       valid_nxt[i] = 1'b1;
      else if (invEn && invIdx == LOG_DEPTH'(i)) valid_nxt[i] = 1'b0;
      else if (flush)                            valid_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) tags[wrIdx] <= wrTag;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      count_q <= popcnt(valid_nxt);
    end
  end

  // Descending scan so the lowest invalid index wins.
  always_comb begin
    freeIdx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) freeIdx = LOG_DEPTH'(i);
    end
  end

  assign full  = &valid_q;
  assign count = count_q;

  // Ascending scan so the highest matching index wins.
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (tags[i] == a_tag);
      if (match[i]) idx_c = LOG_DEPTH'(i);
    end
  end

  assign hit_c = |match;

  assign stall          = r_valid && !lk.respReady;
  assign lk.lookupReady = !(a_valid && stall);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      a_valid <= 1'b0;
      a_tag   <= '0;
      r_valid <= 1'b0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
    end else begin
      if (lk.lookupReady) begin
        a_valid <= lk.lookupValid;
        if (lk.lookupValid) a_tag <= lk.lookupTag;
      end
      // A held response stays frozen; only a fresh compare reloads the payload.
      if (!stall) begin
        r_valid <= a_valid;
        if (a_valid) begin
          r_hit <= hit_c;
          r_idx <= idx_c;
        end
      end
    end
  end

  assign lk.respValid = r_valid;
  assign lk.respHit   = r_hit;
  assign lk.respIdx   = r_idx;

`ifdef TAG_CAM_MULTIHIT_EN
  logic r_multi;
  // More than one bit set: clearing the lowest set bit leaves something behind.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_multi <= 1'b0;
    else if (!stall && a_valid) r_multi <= (match & (match - DEPTH'(1))) != '0;
  end
  assign lk.respMultiHit = r_multi;
`else
  assign lk.respMultiHit = 1'b0;
`endif

endmodule
